// File: rtl/flag_reg_unit.sv
// Registered ZF/CF/SF/OF flag unit with a LIFO flag stack for call/interrupt save/restore.
// Flag vector packing is {zf, cf, sf, of} both in the register and on the stack.
module flag_reg_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_valid,
  input  logic [1:0]       mode,
  input  logic             push,
  input  logic             pop,
  output logic             zf,
  output logic             cf,
  output logic             sf,
  output logic             of,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] MODE_CMP  = 2'b00;
  localparam logic [1:0] MODE_TEST = 2'b01;
  localparam logic [1:0] MODE_EQ   = 2'b10;

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [3:0]    stack_q [STACK_DEPTH];

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] andr;
  logic [3:0]       op_flags;
  logic             push_ok, pop_ok;
  logic [IW-1:0]    wr_idx, rd_idx;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CW'(STACK_DEPTH));
  assign stack_err   = err_q;
  assign {zf, cf, sf, of} = flags_q;

  // push and pop together cancel each other; only the error pulse remains
  assign push_ok = push & ~pop & ~stack_full;
  assign pop_ok  = pop & ~push & ~stack_empty;
  assign err_d   = (push & pop) | (push & ~pop & stack_full) | (pop & ~push & stack_empty);

  // Indices are only used when the matching request is legal, so truncation is safe
  assign wr_idx = IW'(count_q);
  assign rd_idx = IW'(count_q - CW'(1));

  always_comb begin
    diff     = {1'b0, a} - {1'b0, b};
    andr     = a & b;
    op_flags = flags_q;
    case (mode)
      MODE_CMP:  op_flags = {diff[WIDTH-1:0] == '0, diff[WIDTH], diff[WIDTH-1],
                            (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])};
      MODE_TEST: op_flags = {andr == '0, 1'b0, andr[WIDTH-1], 1'b0};
      MODE_EQ:   op_flags = {a == b, flags_q[2:0]};
      default:   op_flags = flags_q;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    if (pop_ok)        flags_d = stack_q[rd_idx];
    else if (op_valid) flags_d = op_flags;
    if (push_ok)       count_d = count_q + CW'(1);
    else if (pop_ok)   count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack payload needs no reset: entries are only read below the live count
  always_ff @(posedge clk) begin
    if (!rst && push_ok) stack_q[wr_idx] <= flags_q;
  end

endmodule
